// File: rtl/game_state_controller_pkg.sv
// Shared game encodings and helpers for the game sequencer and its renderer overlays.
// The state values are visible on game_state, so the numbering is part of the interface.
package game_state_controller_pkg;

  localparam int GAME_STATE_W = 3;
  localparam int LIVES_W      = 4;

  typedef enum logic [GAME_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_GAME_OVER = 3'd3,
    ST_WIN       = 3'd4
  } game_state_e;

  function automatic logic [7:0] sat_dec8(input logic [7:0] value);
    return (value == 8'd0) ? 8'd0 : value - 8'd1;
  endfunction

endpackage

// File: rtl/game_state_controller_key_debouncer.sv
// Key debouncer: 2-FF synchroniser, falling-edge press detect and a game-tick lockout.
// The lockout is armed by the consumer through accept, so dropped presses leave it idle.
module game_state_controller_key_debouncer
  import game_state_controller_pkg::*;
#(
  parameter logic [7:0] DEBOUNCE_TICKS = 8'd6
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_n,
  input  logic accept,
  output logic press
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [7:0] lock_cnt_q;
  logic [7:0] lock_cnt_d;

  // The key idles high, so the synchroniser resets high to avoid a false press on release of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= 1'b1;
      sync_q     <= 1'b1;
      prev_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
    end else begin
      meta_q     <= key_n;
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (accept) begin
      lock_cnt_d = DEBOUNCE_TICKS;
    end else if (tick) begin
      lock_cnt_d = sat_dec8(lock_cnt_q);
    end
  end

  assign press = prev_q & ~sync_q & (lock_cnt_q == 8'd0);

endmodule

// File: rtl/game_state_controller.sv
// Top-level game sequencer: gates the game tick, runs the game FSM, qualifies hits,
// counts lives, times invulnerability and detects the win condition.
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter logic [LIVES_W-1:0] START_LIVES    = 4'd3,
  parameter logic [7:0]         WIN_LEVEL      = 8'd10,
  parameter logic [7:0]         INVULN_TICKS   = 8'd30,
  parameter logic [7:0]         END_HOLD_TICKS = 8'd120,
  parameter logic [7:0]         DEBOUNCE_TICKS = 8'd6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_en_in,
  input  logic                    start_key,
  input  logic                    collision_in,
  input  logic [7:0]              bank_level,
  output logic                    game_en_out,
  output logic                    soft_reset,
  output logic                    hit_pulse,
  output logic [LIVES_W-1:0]      lives,
  output logic                    invulnerable,
  output logic                    flash,
  output logic [GAME_STATE_W-1:0] game_state
);

  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [7:0]         invuln_cnt_q, invuln_cnt_d;
  logic [7:0]         end_cnt_q, end_cnt_d;
  logic               coll_prev_q, coll_prev_d;
  logic               game_en_out_q, game_en_out_d;
  logic               soft_reset_q, soft_reset_d;
  logic               hit_pulse_q, hit_pulse_d;

  logic press;
  logic accept;
  logic playing_tick;
  logic hit;

  game_state_controller_key_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_start_key (
    .clk   (clk),
    .rst   (rst),
    .tick  (game_en_in),
    .key_n (start_key),
    .accept(accept),
    .press (press)
  );

  assign playing_tick = game_en_in & (state_q == ST_PLAYING);
  // A contact counts only on its rising sample, and never while immune.
  assign hit = playing_tick & collision_in & ~coll_prev_q & (invuln_cnt_q == 8'd0);

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    invuln_cnt_d  = invuln_cnt_q;
    end_cnt_d     = end_cnt_q;
    coll_prev_d   = coll_prev_q;
    soft_reset_d  = 1'b0;
    accept        = 1'b0;
    game_en_out_d = playing_tick;
    hit_pulse_d   = hit;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          accept       = 1'b1;
          state_d      = ST_PLAYING;
          lives_d      = START_LIVES;
          invuln_cnt_d = 8'd0;
          end_cnt_d    = 8'd0;
          coll_prev_d  = 1'b0;
          soft_reset_d = 1'b1;
        end
      end

      ST_PLAYING: begin
        if (playing_tick) begin
          coll_prev_d  = collision_in;
          invuln_cnt_d = sat_dec8(invuln_cnt_q);
        end
        if (hit) begin
          lives_d      = (lives_q == '0) ? '0 : lives_q - 1'b1;
          invuln_cnt_d = INVULN_TICKS;
        end
        // Hit is resolved first: losing the last life beats both a win and a pause.
        if (hit && (lives_q <= 4'd1)) begin
          state_d = ST_GAME_OVER;
        end else if (playing_tick && (bank_level >= WIN_LEVEL)) begin
          state_d = ST_WIN;
        end else if (press) begin
          accept  = 1'b1;
          state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (press) begin
          accept  = 1'b1;
          state_d = ST_PLAYING;
        end
      end

      ST_GAME_OVER, ST_WIN: begin
        if (game_en_in && (end_cnt_q < END_HOLD_TICKS)) begin
          end_cnt_d = end_cnt_q + 8'd1;
        end
        if (press && (end_cnt_q == END_HOLD_TICKS)) begin
          accept    = 1'b1;
          state_d   = ST_IDLE;
          end_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lives_q       <= START_LIVES;
      invuln_cnt_q  <= 8'd0;
      end_cnt_q     <= 8'd0;
      coll_prev_q   <= 1'b0;
      game_en_out_q <= 1'b0;
      soft_reset_q  <= 1'b0;
      hit_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      invuln_cnt_q  <= invuln_cnt_d;
      end_cnt_q     <= end_cnt_d;
      coll_prev_q   <= coll_prev_d;
      game_en_out_q <= game_en_out_d;
      soft_reset_q  <= soft_reset_d;
      hit_pulse_q   <= hit_pulse_d;
    end
  end

  assign game_en_out  = game_en_out_q;
  assign soft_reset   = soft_reset_q;
  assign hit_pulse    = hit_pulse_q;
  assign lives        = lives_q;
  assign invulnerable = (invuln_cnt_q != 8'd0);
  assign flash        = invulnerable & invuln_cnt_q[2];
  assign game_state   = state_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: reset, start, hits, pause, end hold, win and mid-game reset.
module tb_game_state_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_en_in = 1'b0;
  logic       start_key = 1'b1;
  logic       collision_in = 1'b0;
  logic [7:0] bank_level = 8'd0;

  logic       game_en_out;
  logic       soft_reset;
  logic       hit_pulse;
  logic [3:0] lives;
  logic       invulnerable;
  logic       flash;
  logic [2:0] game_state;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   sr_cycles = 0;
  int   hits = 0;
  logic last_en = 1'b0;
  logic last_hit = 1'b0;
  logic en_after = 1'b0;
  logic en_seen = 1'b0;

  always #5 clk = ~clk;

  game_state_controller dut (
    .clk         (clk),
    .rst         (rst),
    .game_en_in  (game_en_in),
    .start_key   (start_key),
    .collision_in(collision_in),
    .bank_level  (bank_level),
    .game_en_out (game_en_out),
    .soft_reset  (soft_reset),
    .hit_pulse   (hit_pulse),
    .lives       (lives),
    .invulnerable(invulnerable),
    .flash       (flash),
    .game_state  (game_state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One game tick: game_en_in high for a single cycle, outputs sampled one and two cycles later.
  task automatic applyStimulus();
    @(negedge clk);
    game_en_in = 1'b1;
    @(negedge clk);
    game_en_in = 1'b0;
    last_en  = game_en_out;
    last_hit = hit_pulse;
    if (game_en_out) en_seen = 1'b1;
    if (hit_pulse) hits++;
    @(negedge clk);
    en_after = game_en_out;
    if (game_en_out) en_seen = 1'b1;
  endtask

  task automatic applyPress();
    sr_cycles = 0;
    @(negedge clk);
    start_key = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (soft_reset) sr_cycles++;
    end
    start_key = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (soft_reset) sr_cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while rst is held low
    repeat (3) @(negedge clk);
    checkOutput("rst_state", game_state, 0);
    checkOutput("rst_lives", lives, 3);
    checkOutput("rst_en", game_en_out, 0);
    checkOutput("rst_soft", soft_reset, 0);
    checkOutput("rst_hit", hit_pulse, 0);
    checkOutput("rst_flash", flash, 0);
    rst = 1'b1;

    en_seen = 1'b0;
    repeat (50) applyStimulus();
    checkOutput("idle_en_never", en_seen, 0);
    checkOutput("idle_state", game_state, 0);
    checkOutput("idle_lives", lives, 3);

    // Start a game
    applyPress();
    checkOutput("start_soft_cycles", sr_cycles, 1);
    checkOutput("start_state", game_state, 1);
    applyStimulus();
    checkOutput("tick_en_delayed", last_en, 1);
    checkOutput("tick_en_one_cycle", en_after, 0);

    // Held contact, ignored contact while immune, later counted contact
    hits = 0;
    for (int t = 0; t <= 35; t++) begin
      collision_in = (t < 10) || (t >= 20 && t < 25) || (t == 35);
      applyStimulus();
      if (t == 0) begin
        checkOutput("hit_first", last_hit, 1);
        checkOutput("hit_with_en", last_en, 1);
        checkOutput("flash_on_cnt30", flash, 1);
      end
      if (t == 3) checkOutput("flash_off_cnt27", flash, 0);
      if (t == 9) begin
        checkOutput("held_hits", hits, 1);
        checkOutput("lives_after_hit", lives, 2);
      end
      if (t == 29) checkOutput("invuln_tick29", invulnerable, 1);
      if (t == 30) checkOutput("invuln_tick30", invulnerable, 0);
      if (t == 34) checkOutput("contact20_ignored", hits, 1);
    end
    collision_in = 1'b0;
    checkOutput("contact35_hits", hits, 2);
    checkOutput("contact35_lives", lives, 1);

    // Pause freezes immunity; resume and a bounce inside the lockout
    repeat (5) applyStimulus();
    applyPress();
    checkOutput("pause_state", game_state, 2);
    en_seen = 1'b0;
    repeat (40) applyStimulus();
    checkOutput("pause_en_never", en_seen, 0);
    checkOutput("pause_invuln_frozen", invulnerable, 1);
    applyPress();
    checkOutput("resume_state", game_state, 1);
    checkOutput("resume_no_soft", sr_cycles, 0);
    applyPress();
    checkOutput("bounce_ignored", game_state, 1);
    repeat (24) applyStimulus();
    checkOutput("invuln_left_1", invulnerable, 1);
    applyStimulus();
    checkOutput("invuln_left_0", invulnerable, 0);

    // Last life lost on the same tick as the win level
    collision_in = 1'b1;
    bank_level = 8'd10;
    applyStimulus();
    checkOutput("last_hit_pulse", last_hit, 1);
    checkOutput("hit_win_state", game_state, 3);
    checkOutput("hit_win_lives", lives, 0);
    collision_in = 1'b0;
    bank_level = 8'd0;

    // End hold: early presses dropped without arming the lockout
    en_seen = 1'b0;
    repeat (50) applyStimulus();
    checkOutput("over_en_never", en_seen, 0);
    applyPress();
    checkOutput("press_end50", game_state, 3);
    repeat (69) applyStimulus();
    applyPress();
    checkOutput("press_end119", game_state, 3);
    applyStimulus();
    applyPress();
    checkOutput("press_end120", game_state, 0);

    // New game, three separated hits
    repeat (8) applyStimulus();
    applyPress();
    checkOutput("new_soft_cycles", sr_cycles, 1);
    checkOutput("new_lives", lives, 3);
    checkOutput("new_invuln_clear", invulnerable, 0);
    hits = 0;
    applyStimulus();
    for (int h = 0; h < 3; h++) begin
      collision_in = 1'b1;
      applyStimulus();
      collision_in = 1'b0;
      repeat (31) applyStimulus();
    end
    checkOutput("three_hits", hits, 3);
    checkOutput("three_lives", lives, 0);
    checkOutput("three_state", game_state, 3);
    en_seen = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("three_en_low", en_seen, 0);
    repeat (80) applyStimulus();
    applyPress();
    checkOutput("three_to_idle", game_state, 0);

    // Reset in the middle of a game
    repeat (8) applyStimulus();
    applyPress();
    collision_in = 1'b1;
    applyStimulus();
    collision_in = 1'b0;
    checkOutput("mid_lives_before", lives, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_state", game_state, 0);
    checkOutput("mid_rst_lives", lives, 3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sr_cycles = 0;
    repeat (4) begin
      @(negedge clk);
      if (soft_reset) sr_cycles++;
    end
    checkOutput("mid_rst_no_soft", sr_cycles, 0);

    // Win with lives remaining
    applyPress();
    checkOutput("win_start_state", game_state, 1);
    applyStimulus();
    collision_in = 1'b1;
    applyStimulus();
    collision_in = 1'b0;
    repeat (31) applyStimulus();
    bank_level = 8'd10;
    applyStimulus();
    checkOutput("win_state", game_state, 4);
    checkOutput("win_lives", lives, 2);
    applyStimulus();
    checkOutput("win_en_low", last_en, 0);
    bank_level = 8'd0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
